rfphoenix_vec_alu_strip: RTL and testbench
==========================================

# rfphoenix_vec_alu_strip

Strip-mined, multi-cycle vector ALU for the rfPhoenix vector pipe. It accepts one vector operation per handshake, captures the operands, and processes NLANES lanes SLICE lanes per clock through a narrow datapath. Lane permutes (extract, shuffle, whole-lane shift) complete in a single full-width beat. Results are held until the consumer takes them. It is the area-reduced, parametrised successor to the fully parallel vector ALU: it adds configurable lane count, slice width and per-lane write masking, and supports packed or broadcast compare results.

## Interface
- NLANES, 16: vector lanes; power of two, at least 2.
- SLICE, 4: lanes processed per beat; power of two; divides NLANES.
- LANEW, 32: lane width in bits.
- NB (localparam), NLANES/SLICE: beats per lane-wise op.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of any op in flight.
- in_valid  in  1  op and operands valid.
- in_ready  out  1  high only in IDLE with flush low.
- op  in  4  vec_op_t: ADD=0, SUB=1, AND=2, OR=3, XOR=4, CEQ=5, CLT=6 (signed), CLTU=7, VEX=8, VSHUF=9, VSLL=10, VSRL=11.
- pack  in  1  compare result format: 1 = packed bit vector, 0 = per-lane all-ones or zero.
- a, b, t  in  NLANES*LANEW  source operands and old target value.
- imm  in  LANEW  immediate; low log2(NLANES) bits select a lane or a shift count.
- mask  in  NLANES  write enable per lane; masked-off lanes return t.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- o  out  NLANES*LANEW  result.
- err  out  1  illegal op; qualified by out_valid.

## Operation
- States: IDLE, RUN, PERM, DONE.
- IDLE, in_valid && in_ready:
  - Latch op, pack, a, b, t, imm and mask.
  - Clear beat counter bc.
  - op 0–7 goes to RUN; op 8–11 goes to PERM.
  - Ops 12–15 go to DONE with o = t and err = 1.
- RUN: each beat handles lanes bc*SLICE .. bc*SLICE+SLICE-1.
  - ADD and SUB wrap modulo 2^LANEW.
  - CLT compares signed; CLTU compares unsigned.
  - pack=0 compare: lane result is all-ones when true, zero when false.
  - pack=1 compare: result bit for lane i goes to o lane 0 bit i; lanes 1..NLANES-1 and lane 0 bits above NLANES-1 are zero; mask is ignored.
  - Lane-wise ops with mask[i]=0: lane i = t[i].
  - After beat bc=NB-1, go to DONE.
- PERM: one beat over all lanes, mask applied.
  - VEX: every lane = a[imm].
  - VSHUF: lane i = a[b[i] mod NLANES].
  - VSLL: lane i = a[i-imm] when i >= imm, else 0.
  - VSRL: lane i = a[i+imm] when i+imm < NLANES, else 0.
  - Then go to DONE.
- DONE: out_valid=1; o and err are stable. When out_ready is high, go to IDLE.
- flush in any state: go to IDLE, drop out_valid, do not accept a new op that cycle. flush overrides out_ready and in_valid.
- Reset values: state=IDLE, bc=0, o=0, err=0, out_valid=0. in_ready=1 once reset is released.

## Timing
- Accept at edge E0.
- Lane-wise op: out_valid rises at edge E0+NB+1. Default parameters give 5 cycles.
- Permute or illegal op: out_valid at E0+2 for permute, E0+1 for illegal.
- No pipelining across ops. After DONE is consumed, the next accept happens no earlier than the following cycle.
- out_valid stays high with o unchanged until out_ready; back-pressure has no limit.
- in_ready is combinational from state and flush.
- Operands may change after accept without affecting the result.
- Reset mid-op clears immediately; no partial result is emitted.

## Structure
- rfPhoenixPkg gains: vec_op_t enum, VecValue sized by NLANES*LANEW, and the compare-pack helper constants.
- One sub-module, rfphoenix_vec_slice: combinational, SLICE lanes wide. Inputs are op, operand slices and mask slice; outputs are SLICE result lanes plus SLICE compare bits.
- Permute logic sits in the top module as full-width muxes.

## Test plan
- ADD, a lane i=i, b=all 0x10, mask=0xFFFF -> lane i=i+0x10; out_valid exactly 5 cycles after accept.
- SUB, mask=0x00FF, a=0, b=1, t=0xDEAD -> lanes 0–7 = 0xFFFFFFFF, lanes 8–15 = 0xDEAD.
- CLT pack=1, a lane i=i-8 (signed), b=0 -> o lane 0 = 0x000000FF, other lanes 0. Same op with pack=0 -> lanes 0–7 all-ones, rest 0.
- VSHUF, b lane i=15-i, then VSLL imm=3 -> lanes reversed; then lanes 0–2 = 0 and lane 3 = a[0]; out_valid 2 cycles after each accept.
- out_ready held low 10 cycles -> o stable, in_ready=0. Then one out_ready pulse -> in_ready high next cycle; back-to-back op is accepted.
- flush at beat 2 of an ADD, and separately rst_n low during RUN -> no out_valid, IDLE next cycle; a following op completes correctly. op=13 -> err=1, o=t after 1 cycle.

Source files
------------

// File: rtl/rfphoenix_vec_alu_strip_pkg.sv
// Shared types for the strip-mined vector ALU: op encoding, FSM states,
// default geometry and the compare-classification helper.
package rfphoenix_vec_alu_strip_pkg;
  localparam int NLANES_D = 16;
  localparam int SLICE_D  = 4;
  localparam int LANEW_D  = 32;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
    OP_XOR = 4'd4, OP_CEQ = 4'd5, OP_CLT = 4'd6, OP_CLTU = 4'd7,
    OP_VEX = 4'd8, OP_VSHUF = 4'd9, OP_VSLL = 4'd10, OP_VSRL = 4'd11
  } vec_op_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PERM, ST_DONE} state_t;

  typedef logic [NLANES_D-1:0][LANEW_D-1:0] vec_value_t;

  localparam logic [3:0] OP_FIRST_PERM = 4'd8;
  localparam logic [3:0] OP_FIRST_ILL  = 4'd12;

  function automatic logic is_cmp(input logic [3:0] op);
    return (op == OP_CEQ) || (op == OP_CLT) || (op == OP_CLTU);
  endfunction
endpackage

// File: rtl/rfphoenix_vec_alu_strip_if.sv
// Request/response bundle of the vector ALU; master drives operands and
// consumes results, slave is the ALU.
interface rfphoenix_vec_alu_strip_if #(
  parameter int NLANES = 16,
  parameter int LANEW  = 32
);
  logic                          flush;
  logic                          in_valid;
  logic                          in_ready;
  logic [3:0]                    op;
  logic                          pack;
  logic [NLANES-1:0][LANEW-1:0]  a, b, t;
  logic [LANEW-1:0]              imm;
  logic [NLANES-1:0]             mask;
  logic                          out_valid;
  logic                          out_ready;
  logic [NLANES-1:0][LANEW-1:0]  o;
  logic                          err;

  modport master (output flush, in_valid, op, pack, a, b, t, imm, mask, out_ready,
                  input  in_ready, out_valid, o, err);
  modport slave  (input  flush, in_valid, op, pack, a, b, t, imm, mask, out_ready,
                  output in_ready, out_valid, o, err);
endinterface

// File: rtl/rfphoenix_vec_alu_strip_slice.sv
// Combinational lane-wise ALU for SLICE lanes; results already merged with
// the old target under the write mask, raw compare bits exposed for packing.
module rfphoenix_vec_slice
  import rfphoenix_vec_alu_strip_pkg::*;
#(
  parameter int SLICE = 4,
  parameter int LANEW = 32
) (
  input  vec_op_t                     op_i,
  input  logic [SLICE-1:0][LANEW-1:0] a_i,
  input  logic [SLICE-1:0][LANEW-1:0] b_i,
  input  logic [SLICE-1:0][LANEW-1:0] t_i,
  input  logic [SLICE-1:0]            mask_i,
  output logic [SLICE-1:0][LANEW-1:0] r_o,
  output logic [SLICE-1:0]            cmp_o
);
  for (genvar g = 0; g < SLICE; g++) begin : g_lane
    logic [LANEW-1:0] a, b, res;
    logic             c;
    assign a = a_i[g];
    assign b = b_i[g];
    always_comb begin
      c   = 1'b0;
      res = '0;
      case (op_i)
        OP_ADD:  res = a + b;
        OP_SUB:  res = a - b;
        OP_AND:  res = a & b;
        OP_OR:   res = a | b;
        OP_XOR:  res = a ^ b;
        OP_CEQ:  c = (a == b);
        OP_CLT:  c = ($signed(a) < $signed(b));
        OP_CLTU: c = (a < b);
        default: ;
      endcase
      if (is_cmp(op_i)) res = {LANEW{c}};
    end
    assign cmp_o[g] = c;
    assign r_o[g]   = mask_i[g] ? res : t_i[g];
  end
endmodule

// File: rtl/rfphoenix_vec_alu_strip.sv
// Strip-mined vector ALU: lane-wise ops take NLANES/SLICE beats through one
// slice, permutes take a single full-width beat; result held until consumed.
module rfphoenix_vec_alu_strip
  import rfphoenix_vec_alu_strip_pkg::*;
#(
  parameter int NLANES = NLANES_D,
  parameter int SLICE  = SLICE_D,
  parameter int LANEW  = LANEW_D
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rfphoenix_vec_alu_strip_if.slave bus
);
  localparam int NB  = NLANES / SLICE;
  localparam int LW  = $clog2(NLANES);
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;

  typedef logic [NLANES-1:0][LANEW-1:0] vec_t;

  state_t                      state_q, state_d;
  logic [BCW-1:0]              bc_q;
  logic [3:0]                  op_q;
  logic                        pack_q, err_q, accept;
  vec_t                        a_q, b_q, t_q, o_q, perm;
  logic [LW-1:0]               sh_q;
  logic [NLANES-1:0]           mask_q;
  logic [SLICE-1:0][LANEW-1:0] sl_r;
  logic [SLICE-1:0]            sl_cmp;
  logic                        unused_imm;

  assign bus.in_ready  = (state_q == ST_IDLE) && !bus.flush;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.o         = o_q;
  assign bus.err       = err_q;
  // Only the low log2(NLANES) bits of imm carry a lane index / shift count.
  assign unused_imm    = ^bus.imm[LANEW-1:LW];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)
                 state_d = (bus.op < OP_FIRST_PERM) ? ST_RUN :
                           (bus.op < OP_FIRST_ILL)  ? ST_PERM : ST_DONE;
      ST_RUN:  if (bc_q == BCW'(NB - 1)) state_d = ST_DONE;
      ST_PERM: state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;

  rfphoenix_vec_slice #(.SLICE(SLICE), .LANEW(LANEW)) u_slice (
    .op_i   (vec_op_t'(op_q)),
    .a_i    (a_q[bc_q*SLICE +: SLICE]),
    .b_i    (b_q[bc_q*SLICE +: SLICE]),
    .t_i    (t_q[bc_q*SLICE +: SLICE]),
    .mask_i (mask_q[bc_q*SLICE +: SLICE]),
    .r_o    (sl_r),
    .cmp_o  (sl_cmp)
  );

  // Full-width permute network; shifted-out source positions read as zero.
  for (genvar g = 0; g < NLANES; g++) begin : g_perm
    localparam logic [LW-1:0] GI = LW'(g);
    logic [LW-1:0]    dn;
    logic [LW:0]      up;
    logic [LANEW-1:0] pv;
    assign dn = GI - sh_q;
    assign up = {1'b0, GI} + {1'b0, sh_q};
    always_comb begin
      pv = '0;
      case (op_q)
        OP_VEX:   pv = a_q[sh_q];
        OP_VSHUF: pv = a_q[b_q[g][LW-1:0]];
        OP_VSLL:  if (GI >= sh_q) pv = a_q[dn];
        OP_VSRL:  if (!up[LW]) pv = a_q[up[LW-1:0]];
        default:  ;
      endcase
    end
    assign perm[g] = mask_q[g] ? pv : t_q[g];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bc_q <= '0; op_q <= '0; pack_q <= 1'b0; err_q <= 1'b0;
      a_q <= '0; b_q <= '0; t_q <= '0; o_q <= '0;
      sh_q <= '0; mask_q <= '0;
    end else if (!bus.flush) begin
      case (state_q)
        ST_IDLE: if (accept) begin
          op_q   <= bus.op;
          pack_q <= bus.pack;
          a_q    <= bus.a;
          b_q    <= bus.b;
          t_q    <= bus.t;
          sh_q   <= bus.imm[LW-1:0];
          mask_q <= bus.mask;
          bc_q   <= '0;
          err_q  <= (bus.op >= OP_FIRST_ILL);
          // Cleared so packed compares leave unused bits and lanes at zero.
          o_q    <= (bus.op >= OP_FIRST_ILL) ? bus.t : '0;
        end
        ST_RUN: begin
          bc_q <= bc_q + 1'b1;
          if (pack_q && is_cmp(op_q)) o_q[0][bc_q*SLICE +: SLICE] <= sl_cmp;
          else                        o_q[bc_q*SLICE +: SLICE]    <= sl_r;
        end
        ST_PERM: o_q <= perm;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_rfphoenix_vec_alu_strip.sv
// Directed bench for the strip-mined vector ALU with hand-derived results.
module tb_rfphoenix_vec_alu_strip;
  import rfphoenix_vec_alu_strip_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rfphoenix_vec_alu_strip_if #(.NLANES(16), .LANEW(32)) bus();
  rfphoenix_vec_alu_strip #(.NLANES(16), .SLICE(4), .LANEW(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic issue(input logic [3:0] op, input logic pk, input vec_value_t a,
                       input vec_value_t b, input vec_value_t t,
                       input logic [31:0] imm, input logic [15:0] mask);
    @(negedge clk);
    bus.op = op; bus.pack = pk; bus.a = a; bus.b = b; bus.t = t;
    bus.imm = imm; bus.mask = mask; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // cyc = n means out_valid is first seen high just before edge E0+n.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.out_valid && cyc < 40);
  endtask

  task automatic consume();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.o !== '0) begin n_bad++; $display("FAIL reset_o: got %h want 0", bus.o); end
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_add();
    vec_value_t a, b, t, e;
    int cyc;
    for (int i = 0; i < 16; i++) begin
      a[i] = 32'(i); b[i] = 32'h10; t[i] = 32'hFFFF_0000; e[i] = 32'(i + 16);
    end
    issue(4'(OP_ADD), 1'b0, a, b, t, 32'h0, 16'hFFFF);
    wait_valid(cyc);
    n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL add_latency: got %0d want 5", cyc); end
    n_cmp++; if (bus.o !== e) begin n_bad++; $display("FAIL add_result: got %h want %h", bus.o, e); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL add_err: got %b want 0", bus.err); end
    consume();
  endtask

  task automatic test_sub_mask();
    vec_value_t a, b, t, e;
    int cyc;
    for (int i = 0; i < 16; i++) begin
      a[i] = 32'h0; b[i] = 32'h1; t[i] = 32'hDEAD;
      e[i] = (i < 8) ? 32'hFFFF_FFFF : 32'hDEAD;
    end
    issue(4'(OP_SUB), 1'b0, a, b, t, 32'h0, 16'h00FF);
    wait_valid(cyc);
    n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL sub_latency: got %0d want 5", cyc); end
    n_cmp++; if (bus.o !== e) begin n_bad++; $display("FAIL sub_mask_result: got %h want %h", bus.o, e); end
    consume();
  endtask

  task automatic test_compare();
    vec_value_t a, b, t, e;
    int cyc;
    for (int i = 0; i < 16; i++) begin
      a[i] = 32'(i - 8); b[i] = 32'h0; t[i] = 32'h5555_5555;
    end
    // Packed: mask ignored, all other lanes zero.
    e = '0; e[0] = 32'h0000_00FF;
    issue(4'(OP_CLT), 1'b1, a, b, t, 32'h0, 16'h00F0);
    wait_valid(cyc);
    n_cmp++; if (bus.o !== e) begin n_bad++; $display("FAIL clt_packed: got %h want %h", bus.o, e); end
    consume();
    for (int i = 0; i < 16; i++) e[i] = (i < 8) ? 32'hFFFF_FFFF : 32'h0;
    issue(4'(OP_CLT), 1'b0, a, b, t, 32'h0, 16'hFFFF);
    wait_valid(cyc);
    n_cmp++; if (bus.o !== e) begin n_bad++; $display("FAIL clt_broadcast: got %h want %h", bus.o, e); end
    consume();
    // Unsigned: negatives are huge, so only lanes 8..12 (0..4) are below 5.
    for (int i = 0; i < 16; i++) b[i] = 32'h5;
    e = '0; e[0] = 32'h0000_1F00;
    issue(4'(OP_CLTU), 1'b1, a, b, t, 32'h0, 16'hFFFF);
    wait_valid(cyc);
    n_cmp++; if (bus.o !== e) begin n_bad++; $display("FAIL cltu_packed: got %h want %h", bus.o, e); end
    consume();
  endtask

  task automatic test_perm();
    vec_value_t a, b, t, e;
    int cyc;
    for (int i = 0; i < 16; i++) begin
      a[i] = 32'h100 + 32'(i); b[i] = 32'(15 - i); t[i] = 32'hEE;
      e[i] = 32'h100 + 32'(15 - i);
    end
    issue(4'(OP_VSHUF), 1'b0, a, b, t, 32'h0, 16'hFFFF);
    wait_valid(cyc);
    n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL vshuf_latency: got %0d want 2", cyc); end
    n_cmp++; if (bus.o !== e) begin n_bad++; $display("FAIL vshuf_result: got %h want %h", bus.o, e); end
    consume();
    for (int i = 0; i < 16; i++) e[i] = (i >= 3) ? 32'h100 + 32'(i - 3) : 32'h0;
    issue(4'(OP_VSLL), 1'b0, a, b, t, 32'h3, 16'hFFFF);
    wait_valid(cyc);
    n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL vsll_latency: got %0d want 2", cyc); end
    n_cmp++; if (bus.o !== e) begin n_bad++; $display("FAIL vsll_result: got %h want %h", bus.o, e); end
    consume();
    for (int i = 0; i < 16; i++)
      e[i] = (i == 15) ? 32'hEE : (i < 14) ? 32'h102 + 32'(i) : 32'h0;
    issue(4'(OP_VSRL), 1'b0, a, b, t, 32'h2, 16'h7FFF);
    wait_valid(cyc);
    n_cmp++; if (bus.o !== e) begin n_bad++; $display("FAIL vsrl_masked: got %h want %h", bus.o, e); end
    consume();
    for (int i = 0; i < 16; i++) e[i] = 32'h105;
    issue(4'(OP_VEX), 1'b0, a, b, t, 32'h25, 16'hFFFF);
    wait_valid(cyc);
    n_cmp++; if (bus.o !== e) begin n_bad++; $display("FAIL vex_result: got %h want %h", bus.o, e); end
    consume();
  endtask

  task automatic test_back_to_back();
    vec_value_t a, b, t, e, e2;
    int cyc;
    for (int i = 0; i < 16; i++) begin
      a[i] = 32'(i); b[i] = 32'h10; t[i] = 32'h0; e[i] = 32'(i + 16);
      e2[i] = 32'hFFFF_FFFF ^ 32'(i);
    end
    issue(4'(OP_ADD), 1'b0, a, b, t, 32'h0, 16'hFFFF);
    for (int i = 0; i < 16; i++) bus.a[i] = 32'hBAD;
    bus.mask = 16'h0;
    wait_valid(cyc);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.o !== e) begin n_bad++; $display("FAIL hold_o c%0d: got %h want %h", k, bus.o, e); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_in_ready c%0d: got %b want 0", k, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    bus.op = 4'(OP_XOR); bus.pack = 1'b0; bus.mask = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin bus.a[i] = 32'hF0F0_0000 + 32'(i); bus.b[i] = 32'h0F0F_FFFF; end
    bus.in_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_out_valid: got %b want 0", bus.out_valid); end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_valid(cyc);
    n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL b2b_latency: got %0d want 5", cyc); end
    n_cmp++; if (bus.o !== e2) begin n_bad++; $display("FAIL b2b_xor: got %h want %h", bus.o, e2); end
    consume();
  endtask

  task automatic test_flush();
    vec_value_t a, b, t, e;
    int cyc;
    logic seen;
    for (int i = 0; i < 16; i++) begin
      a[i] = 32'(i); b[i] = 32'h100; t[i] = 32'h0; e[i] = 32'h100 | 32'(i);
    end
    issue(4'(OP_ADD), 1'b0, a, b, t, 32'h0, 16'hFFFF);
    repeat (3) @(negedge clk);
    bus.flush = 1'b1; bus.in_valid = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
    @(posedge clk);
    #1 bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_idle: got %b want 1", bus.in_ready); end
    seen = bus.out_valid;
    repeat (6) begin @(negedge clk); seen |= bus.out_valid; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL flush_no_valid: got %b want 0", seen); end
    issue(4'(OP_OR), 1'b0, a, b, t, 32'h0, 16'hFFFF);
    wait_valid(cyc);
    n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL post_flush_latency: got %0d want 5", cyc); end
    n_cmp++; if (bus.o !== e) begin n_bad++; $display("FAIL post_flush_or: got %h want %h", bus.o, e); end
    consume();
  endtask

  task automatic test_reset_mid();
    vec_value_t a, b, t, e;
    int cyc;
    logic seen;
    for (int i = 0; i < 16; i++) begin
      a[i] = 32'hFFFF_0000 + 32'(i); b[i] = 32'h00FF_00FF; t[i] = 32'h0;
      e[i] = 32'h00FF_0000 | 32'(i);
    end
    issue(4'(OP_ADD), 1'b0, a, b, t, 32'h0, 16'hFFFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.o !== '0) begin n_bad++; $display("FAIL rst_mid_o: got %h want 0", bus.o); end
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= bus.out_valid; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_valid: got %b want 0", seen); end
    issue(4'(OP_AND), 1'b0, a, b, t, 32'h0, 16'hFFFF);
    wait_valid(cyc);
    n_cmp++; if (bus.o !== e) begin n_bad++; $display("FAIL post_rst_and: got %h want %h", bus.o, e); end
    consume();
  endtask

  task automatic test_illegal();
    vec_value_t a, b, t, e;
    int cyc;
    for (int i = 0; i < 16; i++) begin
      a[i] = 32'h5; b[i] = 32'h3; t[i] = 32'hA000 + 32'(i); e[i] = 32'h2;
    end
    issue(4'd13, 1'b0, a, b, t, 32'h0, 16'h0000);
    wait_valid(cyc);
    n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL ill_latency: got %0d want 1", cyc); end
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL ill_err: got %b want 1", bus.err); end
    n_cmp++; if (bus.o !== t) begin n_bad++; $display("FAIL ill_o: got %h want %h", bus.o, t); end
    consume();
    issue(4'(OP_SUB), 1'b0, a, b, t, 32'h0, 16'hFFFF);
    wait_valid(cyc);
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL ill_err_clear: got %b want 0", bus.err); end
    n_cmp++; if (bus.o !== e) begin n_bad++; $display("FAIL after_ill_sub: got %h want %h", bus.o, e); end
    consume();
  endtask

  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = 4'h0; bus.pack = 1'b0; bus.a = '0; bus.b = '0; bus.t = '0;
    bus.imm = '0; bus.mask = '0;
    test_reset();
    test_add();
    test_sub_mask();
    test_compare();
    test_perm();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
